// File: rtl/huffman_pkg.sv
// Shared constants, FSM state type and code-length helper for the serial Huffman decoder.
package huffman_pkg;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned SYM_W   = 3;
    localparam int unsigned NUM_SYM = 6;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StHold,
        StErr
    } state_e;

    // Masks are contiguous low ones, so the number of set bits is the code length.
    function automatic logic [LEN_W-1:0] popcount(input logic [MAX_LEN-1:0] v);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            n = n + LEN_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/huffman_match.sv
// Combinational code matcher: compares the updated shift register against every table entry
// and reports the lowest-indexed symbol whose code and length both agree.
module huffman_match
    import huffman_pkg::*;
(
    input  logic [MAX_LEN-1:0]              sr_next_i,
    input  logic [LEN_W-1:0]                len_next_i,
    input  logic [NUM_SYM-1:0][MAX_LEN-1:0] hc_i,
    input  logic [NUM_SYM-1:0][MAX_LEN-1:0] mask_i,
    input  logic [NUM_SYM-1:0][LEN_W-1:0]   len_i,
    output logic                            hit_o,
    output logic [SYM_W-1:0]                idx_o
);

    logic [NUM_SYM-1:0] match;

    for (genvar k = 0; k < NUM_SYM; k++) begin : g_cmp
        // A zero-length entry is an unused symbol and must never fire.
        assign match[k] = (len_i[k] != '0) &&
                          (len_next_i == len_i[k]) &&
                          ((sr_next_i & mask_i[k]) == hc_i[k]);
    end

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        // Scan high to low so the lowest matching index is the one left standing.
        for (int k = NUM_SYM - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit_o = 1'b1;
                idx_o = SYM_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder for a 6-symbol table with a one-entry output register.
// Define HUFF_DEC_HIST_EN to add per-symbol consumption counters DCNT1..DCNT6.
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               code_valid,
    input  logic [MAX_LEN-1:0] HC1,
    input  logic [MAX_LEN-1:0] HC2,
    input  logic [MAX_LEN-1:0] HC3,
    input  logic [MAX_LEN-1:0] HC4,
    input  logic [MAX_LEN-1:0] HC5,
    input  logic [MAX_LEN-1:0] HC6,
    input  logic [MAX_LEN-1:0] M1,
    input  logic [MAX_LEN-1:0] M2,
    input  logic [MAX_LEN-1:0] M3,
    input  logic [MAX_LEN-1:0] M4,
    input  logic [MAX_LEN-1:0] M5,
    input  logic [MAX_LEN-1:0] M6,
    input  logic               bit_valid,
    input  logic               bit_data,
    output logic               bit_ready,
    output logic               sym_valid,
    output logic [SYM_W-1:0]   sym_data,
    input  logic               sym_ready,
    output logic               dec_err,
    output logic               tbl_loaded
`ifdef HUFF_DEC_HIST_EN
    ,
    output logic [CNT_W-1:0]   DCNT1,
    output logic [CNT_W-1:0]   DCNT2,
    output logic [CNT_W-1:0]   DCNT3,
    output logic [CNT_W-1:0]   DCNT4,
    output logic [CNT_W-1:0]   DCNT5,
    output logic [CNT_W-1:0]   DCNT6
`endif
);

    state_e                          state_q, state_d;
    logic [MAX_LEN-1:0]              sr_q, sr_d;
    logic [LEN_W-1:0]                len_q, len_d;
    logic [NUM_SYM-1:0][MAX_LEN-1:0] hc_q, hc_d;
    logic [NUM_SYM-1:0][MAX_LEN-1:0] m_q, m_d;
    logic [NUM_SYM-1:0][LEN_W-1:0]   cl_q, cl_d;
    logic                            sym_valid_q, sym_valid_d;
    logic [SYM_W-1:0]                sym_data_q, sym_data_d;
    logic                            dec_err_q, dec_err_d;
    logic                            tbl_loaded_q, tbl_loaded_d;

    logic [NUM_SYM-1:0][MAX_LEN-1:0] hc_in, m_in;
    logic [MAX_LEN-1:0]              sr_next;
    logic [LEN_W-1:0]                len_next;
    logic                            hit;
    logic [SYM_W-1:0]                hit_idx;
    logic                            accept;
    logic                            consume;

    assign hc_in = {HC6, HC5, HC4, HC3, HC2, HC1};
    assign m_in  = {M6, M5, M4, M3, M2, M1};

    assign sr_next  = {sr_q[MAX_LEN-2:0], bit_data};
    assign len_next = len_q + LEN_W'(1);

    huffman_match u_match (
        .sr_next_i  (sr_next),
        .len_next_i (len_next),
        .hc_i       (hc_q),
        .mask_i     (m_q),
        .len_i      (cl_q),
        .hit_o      (hit),
        .idx_o      (hit_idx)
    );

    // A table load wins the cycle, so the bit handshake is withheld while it happens.
    always_comb begin
        bit_ready = 1'b0;
        if (!code_valid) begin
            case (state_q)
                StDecode: bit_ready = 1'b1;
                StHold:   bit_ready = sym_ready;
                default:  bit_ready = 1'b0;
            endcase
        end
    end

    assign accept  = bit_valid & bit_ready;
    assign consume = sym_valid_q & sym_ready;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        len_d        = len_q;
        hc_d         = hc_q;
        m_d          = m_q;
        cl_d         = cl_q;
        sym_valid_d  = sym_valid_q;
        sym_data_d   = sym_data_q;
        dec_err_d    = dec_err_q;
        tbl_loaded_d = tbl_loaded_q;

        if (code_valid) begin
            hc_d = hc_in;
            m_d  = m_in;
            for (int k = 0; k < NUM_SYM; k++) begin
                cl_d[k] = popcount(m_in[k]);
            end
            tbl_loaded_d = 1'b1;
            sr_d         = '0;
            len_d        = '0;
            sym_valid_d  = 1'b0;
            sym_data_d   = '0;
            dec_err_d    = 1'b0;
            state_d      = StDecode;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StDecode, StHold: begin
                    if (consume) begin
                        sym_valid_d = 1'b0;
                        state_d     = StDecode;
                    end
                    if (accept) begin
                        if (hit) begin
                            // Overwrites a symbol consumed this same cycle, keeping full rate.
                            sym_data_d  = hit_idx;
                            sym_valid_d = 1'b1;
                            sr_d        = '0;
                            len_d       = '0;
                            state_d     = StHold;
                        end else if (len_next == LEN_W'(MAX_LEN)) begin
                            dec_err_d   = 1'b1;
                            sym_valid_d = 1'b0;
                            sr_d        = '0;
                            len_d       = '0;
                            state_d     = StErr;
                        end else begin
                            sr_d  = sr_next;
                            len_d = len_next;
                        end
                    end
                end
                StErr: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            sr_q         <= '0;
            len_q        <= '0;
            hc_q         <= '0;
            m_q          <= '0;
            cl_q         <= '0;
            sym_valid_q  <= 1'b0;
            sym_data_q   <= '0;
            dec_err_q    <= 1'b0;
            tbl_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            len_q        <= len_d;
            hc_q         <= hc_d;
            m_q          <= m_d;
            cl_q         <= cl_d;
            sym_valid_q  <= sym_valid_d;
            sym_data_q   <= sym_data_d;
            dec_err_q    <= dec_err_d;
            tbl_loaded_q <= tbl_loaded_d;
        end
    end

    assign sym_valid  = sym_valid_q;
    assign sym_data   = sym_data_q;
    assign dec_err    = dec_err_q;
    assign tbl_loaded = tbl_loaded_q;

`ifdef HUFF_DEC_HIST_EN
    logic [NUM_SYM-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (code_valid) begin
            cnt_d = '0;
        end else if (consume) begin
            for (int k = 0; k < NUM_SYM; k++) begin
                if ((sym_data_q == SYM_W'(k + 1)) && (cnt_q[k] != '1)) begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign DCNT1 = cnt_q[0];
    assign DCNT2 = cnt_q[1];
    assign DCNT3 = cnt_q[2];
    assign DCNT4 = cnt_q[3];
    assign DCNT5 = cnt_q[4];
    assign DCNT6 = cnt_q[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed and randomized checks of huffman_decoder against a symbol-level reference model.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid;
    logic [7:0] hc_v [1:6];
    logic [7:0] m_v  [1:6];
    logic       bit_valid, bit_data, bit_ready;
    logic       sym_valid, sym_ready;
    logic [2:0] sym_data;
    logic       dec_err, tbl_loaded;

    int n_vec = 0;
    int n_err = 0;

    logic       last_acc, last_con, last_brdy, last_vld;
    logic [2:0] last_sym;

    int bitq[$];
    int expq[$];
    int mcnt [1:6];

    int bits_a [7] = '{1, 0, 1, 0, 0, 1, 1};
    int ev_a   [7] = '{1, 0, 1, 0, 0, 0, 1};
    int ed_a   [7] = '{1, 0, 2, 0, 0, 0, 3};
    int hist_syms [9] = '{1, 1, 1, 2, 2, 3, 4, 5, 6};

    always #5 clk = ~clk;

`ifdef HUFF_DEC_HIST_EN
    logic [7:0] dcnt_w [1:6];
    int hist_exp [1:6] = '{3, 2, 1, 1, 1, 1};
`endif

    huffman_decoder u_dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (hc_v[1]),
        .HC2        (hc_v[2]),
        .HC3        (hc_v[3]),
        .HC4        (hc_v[4]),
        .HC5        (hc_v[5]),
        .HC6        (hc_v[6]),
        .M1         (m_v[1]),
        .M2         (m_v[2]),
        .M3         (m_v[3]),
        .M4         (m_v[4]),
        .M5         (m_v[5]),
        .M6         (m_v[6]),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .bit_ready  (bit_ready),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .dec_err    (dec_err),
        .tbl_loaded (tbl_loaded)
`ifdef HUFF_DEC_HIST_EN
        ,
        .DCNT1      (dcnt_w[1]),
        .DCNT2      (dcnt_w[2]),
        .DCNT3      (dcnt_w[3]),
        .DCNT4      (dcnt_w[4]),
        .DCNT5      (dcnt_w[5]),
        .DCNT6      (dcnt_w[6])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, settle, sample the handshake, then step past the edge.
    task automatic cyc(input logic bv, input logic bd, input logic rdy);
        bit_valid = bv;
        bit_data  = bd;
        sym_ready = rdy;
        #1;
        last_brdy = bit_ready;
        last_vld  = sym_valid;
        last_sym  = sym_data;
        last_acc  = bit_valid & bit_ready;
        last_con  = sym_valid & sym_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_table(input int sel);
        for (int k = 1; k <= 6; k++) begin
            hc_v[k] = 8'h00;
            m_v[k]  = 8'h00;
        end
        if (sel == 0) begin
            hc_v[1] = 8'h01; m_v[1] = 8'h01;
            hc_v[2] = 8'h01; m_v[2] = 8'h03;
            hc_v[3] = 8'h03; m_v[3] = 8'h0F;
            hc_v[4] = 8'h02; m_v[4] = 8'h0F;
            hc_v[5] = 8'h01; m_v[5] = 8'h0F;
            hc_v[6] = 8'h00; m_v[6] = 8'h0F;
        end else if (sel == 1) begin
            hc_v[1] = 8'h01; m_v[1] = 8'h01;
        end else begin
            // Canonical code 00, 01, 10, 110, 1110, 1111
            hc_v[1] = 8'h00; m_v[1] = 8'h03;
            hc_v[2] = 8'h01; m_v[2] = 8'h03;
            hc_v[3] = 8'h02; m_v[3] = 8'h03;
            hc_v[4] = 8'h06; m_v[4] = 8'h07;
            hc_v[5] = 8'h0E; m_v[5] = 8'h0F;
            hc_v[6] = 8'h0F; m_v[6] = 8'h0F;
        end
    endtask

    task automatic load(input int sel, input logic bv, input logic bd);
        set_table(sel);
        code_valid = 1'b1;
        cyc(bv, bd, 1'b1);
        code_valid = 1'b0;
        bitq.delete();
        expq.delete();
        for (int k = 1; k <= 6; k++) mcnt[k] = 0;
    endtask

    // Encode a symbol from the current table: code length is the mask popcount, MSB first.
    task automatic push_sym(input int s);
        int len;
        len = $countones(m_v[s]);
        for (int i = len - 1; i >= 0; i--) begin
            bitq.push_back(int'(hc_v[s][i]));
        end
        expq.push_back(s);
    endtask

    task automatic play(input int bvp, input int rdp, input int budget);
        int         n;
        int         e;
        logic       bv, bd, rdy;
        logic       hold_prev;
        logic [2:0] data_prev;
        n = 0;
        hold_prev = 1'b0;
        data_prev = 3'd0;
        while ((bitq.size() != 0 || expq.size() != 0) && n < budget) begin
            bv  = (bitq.size() != 0) && ($urandom_range(99, 0) < bvp);
            bd  = (bitq.size() != 0) ? (bitq[0] != 0) : 1'b0;
            rdy = ($urandom_range(99, 0) < rdp);
            cyc(bv, bd, rdy);
            if (hold_prev) begin
                chk("hold_valid", last_vld, 1);
                chk("hold_data", last_sym, data_prev);
            end
            hold_prev = last_vld & ~rdy;
            data_prev = last_sym;
            if (last_acc) void'(bitq.pop_front());
            if (last_con) begin
                if (expq.size() == 0) begin
                    chk("extra_sym", last_sym, 0);
                end else begin
                    e = expq.pop_front();
                    chk("sym", last_sym, e);
                    if (mcnt[e] < 255) mcnt[e]++;
                end
            end
            n++;
        end
        chk("drained", bitq.size() + expq.size(), 0);
    endtask

    initial begin
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        bit_data   = 1'b0;
        sym_ready  = 1'b0;
        set_table(0);

        #1 reset = 1'b0;
        #2;
        chk("rst_valid", sym_valid, 0);
        chk("rst_data", sym_data, 0);
        chk("rst_err", dec_err, 0);
        chk("rst_tbl", tbl_loaded, 0);
        chk("rst_brdy", bit_ready, 0);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        repeat (3) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("idle_brdy", last_brdy, 0);
            chk("idle_valid", sym_valid, 0);
        end

        // Mid-stream asynchronous reset with a partial code in flight
        load(0, 1'b0, 1'b0);
        chk("load_tbl", tbl_loaded, 1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mrst_tbl", tbl_loaded, 0);
        chk("mrst_brdy", bit_ready, 0);
        chk("mrst_valid", sym_valid, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("post_brdy", last_brdy, 0);
            chk("post_valid", sym_valid, 0);
            chk("post_data", sym_data, 0);
            chk("post_err", dec_err, 0);
            chk("post_tbl", tbl_loaded, 0);
        end

        // Basic decode, full throughput
        load(0, 1'b0, 1'b0);
        chk("basic_tbl", tbl_loaded, 1);
        chk("basic_valid0", sym_valid, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, bits_a[i][0], 1'b1);
            chk("basic_brdy", last_brdy, 1);
            chk("basic_valid", sym_valid, ev_a[i]);
            if (ev_a[i] != 0) chk("basic_data", sym_data, ed_a[i]);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("basic_drain_con", last_con, 1);
        chk("basic_drain", sym_valid, 0);

        // Backpressure
        cyc(1'b1, 1'b1, 1'b0);
        chk("bp_valid", sym_valid, 1);
        chk("bp_data", sym_data, 1);
        repeat (3) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("bp_brdy", last_brdy, 0);
            chk("bp_hold_valid", sym_valid, 1);
            chk("bp_hold_data", sym_data, 1);
        end
        repeat (2) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("bp_rel_brdy", last_brdy, 1);
            chk("bp_rel_con", last_con, 1);
            chk("bp_rel_sym", last_sym, 1);
            chk("bp_rel_valid", sym_valid, 1);
            chk("bp_rel_data", sym_data, 1);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("bp_last_con", last_con, 1);
        chk("bp_last_sym", last_sym, 1);
        chk("bp_end_valid", sym_valid, 0);

        // Error: no code matches within eight bits
        load(1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            chk("err_accept", last_acc, 1);
            chk("err_flag", dec_err, (i == 7) ? 1 : 0);
        end
        chk("err_valid", sym_valid, 0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("err_brdy", last_brdy, 0);
        chk("err_sticky", dec_err, 1);
        load(1, 1'b0, 1'b0);
        chk("err_clear", dec_err, 0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("err_reload_brdy", last_brdy, 1);
        chk("err_reload_sym", sym_data, 1);
        cyc(1'b0, 1'b0, 1'b1);

        // Reload discards a partial code; a bit offered with the load is dropped
        load(0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        load(0, 1'b1, 1'b1);
        chk("rl_valid", sym_valid, 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rl_idle_valid", sym_valid, 0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rl_valid1", sym_valid, 1);
        chk("rl_data1", sym_data, 1);
        cyc(1'b0, 1'b0, 1'b1);

        // Histogram stream with known counts
        load(0, 1'b0, 1'b0);
`ifdef HUFF_DEC_HIST_EN
        for (int k = 1; k <= 6; k++) chk("hist_clear", dcnt_w[k], 0);
`endif
        for (int i = 0; i < 9; i++) push_sym(hist_syms[i]);
        play(100, 100, 200);
`ifdef HUFF_DEC_HIST_EN
        for (int k = 1; k <= 6; k++) chk("hist_dir", dcnt_w[k], hist_exp[k]);
`endif

        // Randomized traffic on a canonical table with random stalls on both sides
        load(2, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) push_sym(int'($urandom_range(6, 1)));
        play(75, 60, 5000);
        chk("rand_err", dec_err, 0);
`ifdef HUFF_DEC_HIST_EN
        for (int k = 1; k <= 6; k++) chk("hist_rand", dcnt_w[k], mcnt[k]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
Serial Huffman decoder and receive-side counterpart of the 6-symbol Huffman encoder. It latches the code table the encoder publishes (HC1..HC6 codes, M1..M6 masks, qualified by code_valid). It then consumes an MSB-first bitstream one bit per cycle and emits decoded symbol indices 1..6 over a valid/ready handshake. It sits downstream of the encoder in the compression path and closes the loop for end-to-end checking.

Parameters:
MAX_LEN, 8, maximum code length in bits; equals HC/M width
SYM_W, 3, symbol index width (values 1..6)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
code_valid  in  1  one-cycle pulse; table inputs are valid this cycle
HC1..HC6  in  8 each  code for symbol k, LSB-aligned
M1..M6  in  8 each  mask for symbol k, contiguous low ones; popcount = code length
bit_valid  in  1  bit_data valid
bit_data  in  1  next stream bit, MSB of each code first
bit_ready  out  1  decoder accepts the bit this cycle
sym_valid  out  1  sym_data valid
sym_data  out  3  decoded symbol 1..6
sym_ready  in  1  downstream accepts the symbol
dec_err  out  1  sticky; no code matched within MAX_LEN bits
tbl_loaded  out  1  a table is held

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; bit_ready=0, sym_valid=0, sym_data=0, dec_err=0, tbl_loaded=0; shift register, length counter and table cleared.
- States: IDLE, DECODE, HOLD, ERR.
- Table load: code_valid=1 in any state latches all 12 inputs. The same edge sets tbl_loaded=1, clears the shift register, length counter, pending symbol and dec_err, and moves to DECODE. code_valid has priority over every other event in that cycle; a bit offered that cycle is not accepted.
- Lengths are precomputed at load: len_k = popcount(M_k). A mask with len_k=0 marks symbol k as unused and it never matches.
- IDLE: bit_ready=0. Moves to DECODE only via a table load.
- DECODE: bit_ready=1.
  - On accept: sr <= {sr[MAX_LEN-2:0], bit_data}, len <= len+1.
  - Match test uses the updated sr and len: (sr_next & M_k) == HC_k and len_next == len_k.
  - If several symbols match, the lowest k wins. A well-formed prefix table makes this unreachable.
  - On a match: sym_data <= k and sym_valid <= 1 at the next edge. Latency is 1 cycle from accepting the completing bit. sr and len clear.
  - No match and len_next == MAX_LEN: dec_err <= 1, go to ERR.
- Output register (1 entry): while sym_valid=1 and sym_ready=0, state is HOLD and bit_ready=0.
  - When sym_ready=1 and sym_valid=1, the symbol is consumed.
  - bit_ready is combinational: 1 in DECODE, and in HOLD when sym_ready=1. This allows full throughput of one bit per cycle with back-to-back 1-bit codes.
  - If a new symbol completes in the same cycle the old one is consumed, sym_valid stays 1 and sym_data updates.
- ERR: bit_ready=0, sym_valid=0. Only a table load or reset exits.
- A partially received code is discarded by a table load or reset. There is no other flush.
- Widths: len counter is clog2(MAX_LEN+1) bits; sr is MAX_LEN bits; all compares are MAX_LEN wide.

Optional Feature:
HUFF_DEC_HIST_EN:
- Defined: adds outputs DCNT1..DCNT6 (8 bits each).
  - Each increments when its symbol is consumed (sym_valid & sym_ready) and saturates at 255.
  - All clear on reset and on table load.
  - Intended for direct comparison against the encoder's CNT1..CNT6.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package huffman_pkg: MAX_LEN, SYM_W, NUM_SYM=6, state enum, and a popcount function for length derivation.
- One sub-module, huffman_match: combinational. Inputs are sr_next, len_next and the table; outputs are hit and the index of the lowest matching symbol. It is instantiated once.

Test Plan:
- Reset and idle: assert reset mid-stream, then hold code_valid=0 -> all outputs 0, bit_ready stays 0.
- Basic decode:
  - Table: sym1=1/M 01; sym2=01/M 03; sym3=0011, sym4=0010, sym5=0001, sym6=0000, each M 0F.
  - Stream 1,0,1,0,0,1,1 with sym_ready=1 -> symbols 1, 2, 3.
  - Each symbol is valid the cycle after its last bit.
- Backpressure: stream 1,1,1 with sym_ready=0 for 3 cycles -> sym_valid holds sym 1 and bit_ready=0. Releasing sym_ready yields 1, 1, 1 with no loss.
- Error:
  - Table with only sym1=1 (M 01), all other masks 0.
  - Stream of eight 0s -> dec_err=1 after the 8th bit, state ERR, bit_ready=0.
  - A table reload clears dec_err.
- Reload mid-code: send 0,0 under the basic table, then pulse code_valid with the same table -> partial code discarded. A following 1 decodes as sym 1.
- With HUFF_DEC_HIST_EN: stream encoding sym counts {3,2,1,1,1,1} -> DCNT1..6 = 3,2,1,1,1,1.
